uart_word_tx_sequencer: RTL and testbench

//  Serializes one NBITS-wide word from the debug controller (tx_Data/tx_start/tx_done side)

---
 rtl/uart_word_tx_sequencer.sv | 116 +++++++++++
 tb/tb_uart_word_tx_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx_sequencer.sv
// uart_word_tx_sequencer
//
// Purpose:
//   Takes one NBITS-wide word from the debug controller and feeds it to a
//   byte-wide UART transmitter as NBYTES consecutive bytes. Only one word is
//   in flight at a time, and only one byte is handed to the UART at a time.
//   Both sides use a start/done handshake.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   word_data   in   word to send; sampled only when word_start is accepted
//   word_start  in   send request (level or pulse); ignored while busy
//   word_done   out  one-cycle pulse after the UART confirms the last byte
//   busy        out  high from the cycle after accept through word_done
//   byte_data   out  registered byte for the UART; held while the byte is in flight
//   byte_start  out  one-cycle pulse; the UART may latch byte_data
//   byte_done   in   one-cycle pulse from the UART: current byte shifted out
module uart_word_tx_sequencer #(
   parameter int NBITS      = 32,
   parameter int BYTE_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NBITS-1:0]      word_data,
   input  logic                  word_start,
   output logic                  word_done,
   output logic                  busy,
   output logic [BYTE_WIDTH-1:0] byte_data,
   output logic                  byte_start,
   input  logic                  byte_done
);

   localparam int NBYTES = NBITS / BYTE_WIDTH;
   localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int SW     = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [NBITS-1:0]      shreg_q, shreg_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BYTE_WIDTH-1:0] byte_data_q, byte_data_d;

   // The word register is never shifted. The byte for slot k is picked with an
   // indexed part-select. In MSB-first mode the slot order is mirrored.
   function automatic logic [BYTE_WIDTH-1:0] sel_byte(input logic [NBITS-1:0] w,
                                                      input logic [CW-1:0]    k);
      int          idx;
      logic [SW-1:0] base;
      idx  = MSB_FIRST ? (NBYTES - 1 - int'(k)) : int'(k);
      base = SW'(idx * BYTE_WIDTH);
      return w[base +: BYTE_WIDTH];
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         byte_data_q <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         byte_data_q <= byte_data_d;
      end
   end

   // byte_data_d is loaded only on the transitions into START. The byte on the
   // UART side therefore stays stable for the whole time the byte is in flight.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      byte_data_d = byte_data_q;
      case (state_q)
         IDLE: begin
            if (word_start) begin
               shreg_d     = word_data;
               cnt_d       = '0;
               byte_data_d = sel_byte(word_data, '0);
               state_d     = START;
            end
         end
         // A byte_done coinciding with byte_start belongs to no byte of ours.
         START: state_d = WAIT;
         WAIT: begin
            if (byte_done) begin
               if (cnt_q == LAST_CNT) begin
                  state_d = DONE;
               end else begin
                  cnt_d       = cnt_q + CW'(1);
                  byte_data_d = sel_byte(shreg_q, cnt_q + CW'(1));
                  state_d     = START;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign byte_start = (state_q == START);
   assign word_done  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign byte_data  = byte_data_q;

endmodule

// File: tb/tb_uart_word_tx_sequencer.sv
module tb_uart_word_tx_sequencer;

   localparam int NBYTES = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] word_data = '0;
   logic        word_start = 1'b0;
   logic        uart_bd = 1'b0;
   logic        spur_bd = 1'b0;
   logic        byte_done;
   assign byte_done = uart_bd | spur_bd;

   logic       wd0, busy0, bs0, wd1, busy1, bs1;
   logic [7:0] bd0, bd1;

   uart_word_tx_sequencer #(.NBITS(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .word_data(word_data), .word_start(word_start),
      .word_done(wd0), .busy(busy0), .byte_data(bd0), .byte_start(bs0),
      .byte_done(byte_done));

   uart_word_tx_sequencer #(.NBITS(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .word_data(word_data), .word_start(word_start),
      .word_done(wd1), .busy(busy1), .byte_data(bd1), .byte_start(bs1),
      .byte_done(byte_done));

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int wd_count = 0;
   int bs_count = 0;
   int uart_delay = 10;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- reference model (timestamp based) ----------------
   // The model records the cycle on which each byte_start / word_done must occur.
   // It also records the byte stream that the accepted word must produce, in each order.
   int          cyc = 0;
   bit          in_word = 0;
   int          sent = 0;
   int          bs_cyc = -1;
   int          wd_cyc = -1;
   bit          exp_bs = 0, exp_wd = 0, exp_busy = 0;
   logic [7:0]  q0[$];
   logic [7:0]  q1[$];

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         in_word = 0; sent = 0; bs_cyc = -1; wd_cyc = -1;
         q0.delete(); q1.delete();
      end else begin
         cyc = cyc + 1;
         if (in_word && wd_cyc == cyc - 1) begin
            in_word = 0;
            wd_cyc  = -1;
         end else if (!in_word) begin
            if (word_start) begin
               in_word = 1;
               sent    = 1;
               bs_cyc  = cyc;
               for (int k = 0; k < NBYTES; k++) begin
                  q0.push_back(8'(word_data >> (8 * k)));
                  q1.push_back(8'(word_data >> (8 * (NBYTES - 1 - k))));
               end
            end
         end else if (wd_cyc == -1 && byte_done && bs_cyc != cyc - 1) begin
            if (sent == NBYTES) wd_cyc = cyc;
            else begin
               sent   = sent + 1;
               bs_cyc = cyc;
            end
         end
      end
      exp_bs   = reset && (bs_cyc == cyc);
      exp_wd   = reset && (wd_cyc == cyc);
      exp_busy = reset && in_word;
   end

   // ---------------- monitor / scoreboard ----------------
   logic [7:0] last0 = '0, last1 = '0;
   initial forever begin
      @(negedge clk);
      chk("busy_lsb", 32'(busy0), 32'(exp_busy));
      chk("busy_msb", 32'(busy1), 32'(exp_busy));
      chk("byte_start_lsb", 32'(bs0), 32'(exp_bs));
      chk("byte_start_msb", 32'(bs1), 32'(exp_bs));
      chk("word_done_lsb", 32'(wd0), 32'(exp_wd));
      chk("word_done_msb", 32'(wd1), 32'(exp_wd));
      if (!reset) begin
         chk("reset_byte_data_lsb", 32'(bd0), 32'h0);
         chk("reset_byte_data_msb", 32'(bd1), 32'h0);
      end
      if (bs0) begin
         bs_count++;
         checks++;
         if (q0.size() > 0) begin
            passes++;
            last0 = q0.pop_front();
            chk("byte_data_lsb", 32'(bd0), 32'(last0));
         end else $display("FAIL byte_avail_lsb: got unexpected byte %0h, expected none", bd0);
      end else if (exp_busy) begin
         chk("byte_hold_lsb", 32'(bd0), 32'(last0));
      end
      if (bs1) begin
         checks++;
         if (q1.size() > 0) begin
            passes++;
            last1 = q1.pop_front();
            chk("byte_data_msb", 32'(bd1), 32'(last1));
         end else $display("FAIL byte_avail_msb: got unexpected byte %0h, expected none", bd1);
      end else if (exp_busy) begin
         chk("byte_hold_msb", 32'(bd1), 32'(last1));
      end
      if (wd0) begin
         wd_count++;
         chk("all_bytes_sent_lsb", 32'(q0.size()), 32'h0);
         chk("all_bytes_sent_msb", 32'(q1.size()), 32'h0);
      end
   end

   // ---------------- UART model ----------------
   initial forever begin
      @(negedge clk);
      if (bs0 && reset) begin
         @(posedge clk); #1;
         repeat (uart_delay) begin @(posedge clk); #1; end
         uart_bd = 1'b1;
         @(posedge clk); #1;
         uart_bd = 1'b0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_pulse(input logic [31:0] w);
      @(posedge clk); #1;
      word_data  = w;
      word_start = 1'b1;
      @(posedge clk); #1;
      word_start = 1'b0;
   endtask

   task automatic wait_word(input int target);
      int n = 0;
      while (wd_count < target && n < 1000) begin @(negedge clk); n++; end
      chk("word_done_timeout", 32'(wd_count >= target), 32'h1);
   endtask

   task automatic wait_bytes(input int target);
      int n = 0;
      while (bs_count < target && n < 1000) begin @(negedge clk); n++; end
      chk("byte_start_timeout", 32'(bs_count >= target), 32'h1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
      $fatal(1, "timeout");
   end

   int nwd = 0;
   int k;

   initial begin
      // Reset with word_start and byte_done both held high.
      reset = 1'b0; word_start = 1'b1; spur_bd = 1'b1; word_data = 32'h12345678;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1; spur_bd = 1'b0;
      @(posedge clk); #1 word_start = 1'b0;
      wait_word(++nwd);

      // Basic word, UART byte time of 10 cycles.
      uart_delay = 10;
      send_pulse(32'hAABBCCDD);
      wait_word(++nwd);

      // Immediate byte_done.
      uart_delay = 0;
      send_pulse(32'hAABBCCDD);
      wait_word(++nwd);

      // New word request during byte 2 is ignored.
      uart_delay = 6;
      k = bs_count;
      send_pulse(32'hAABBCCDD);
      wait_bytes(k + 2);
      @(posedge clk); #1 word_data = 32'h55667788; word_start = 1'b1;
      @(posedge clk); #1 word_start = 1'b0;
      wait_word(++nwd);

      // Spurious byte_done while idle, then during the byte_start cycle.
      @(posedge clk); #1 spur_bd = 1'b1;
      @(posedge clk); #1 spur_bd = 1'b0;
      uart_delay = 4;
      @(posedge clk); #1 word_data = 32'h0BADF00D; word_start = 1'b1;
      @(posedge clk); #1 word_start = 1'b0; spur_bd = 1'b1;
      @(posedge clk); #1 spur_bd = 1'b0;
      wait_word(++nwd);

      // Reset during byte 3 abandons the word.
      uart_delay = 8;
      k = bs_count;
      send_pulse(32'hCAFEBABE);
      wait_bytes(k + 3);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (12) @(posedge clk);
      chk("no_word_done_after_reset", 32'(wd_count), 32'(nwd));
      send_pulse(32'h13579BDF);
      wait_word(++nwd);

      // Back-to-back words with word_start held high.
      uart_delay = 2;
      @(posedge clk); #1 word_data = 32'h00000001; word_start = 1'b1;
      @(posedge clk); #1 word_data = 32'hFFFFFFFF;
      wait_word(++nwd);
      @(posedge clk);
      @(posedge clk); #1 word_start = 1'b0;
      wait_word(++nwd);

      // Random words, random UART byte times, ignored requests while busy.
      for (int i = 0; i < 20; i++) begin
         uart_delay = $urandom_range(0, 12);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1 spur_bd = 1'b1;
            @(posedge clk); #1 spur_bd = 1'b0;
         end
         send_pulse($urandom);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1 word_data = $urandom; word_start = 1'b1;
            @(posedge clk); #1 word_start = 1'b0;
         end
         wait_word(++nwd);
      end

      repeat (5) @(posedge clk);
      chk("total_word_done", 32'(wd_count), 32'(nwd));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
